// File: rtl/ecc_scrub_ctrl.sv
// SECDED memory controller: arbitrates host accesses against a background scrubber.
// Define ECC_SCRUB_WB_EN to have the scrubber write corrected single-bit errors back.
module ecc_scrub_ctrl #(
  parameter int unsigned DATA_WIDTH     = 23,
  parameter int unsigned PARITY_WIDTH   = 6,
  parameter int unsigned ADDR_WIDTH     = 5,
  parameter int unsigned SCRUB_INTERVAL = 64,
  parameter int unsigned STARVE_LIMIT   = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               scrub_en,
  input  logic                               cfg_bypass,
  input  logic                               cnt_clr,
  input  logic                               host_req,
  input  logic                               host_we,
  input  logic [ADDR_WIDTH-1:0]              host_addr,
  input  logic [DATA_WIDTH-1:0]              host_wdata,
  output logic                               host_gnt,
  output logic                               host_rvalid,
  output logic [DATA_WIDTH-1:0]              host_rdata,
  output logic                               host_sbit_err,
  output logic                               host_dbit_err,
  output logic                               mem_en,
  output logic                               mem_we,
  output logic [ADDR_WIDTH-1:0]              mem_addr,
  output logic [DATA_WIDTH+PARITY_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH+PARITY_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0]              ecc_data_in,
  output logic [PARITY_WIDTH-1:0]            ecc_parity_in,
  output logic                               ecc_bypass,
  input  logic [PARITY_WIDTH-1:0]            ecc_parity_out,
  input  logic [DATA_WIDTH-1:0]              ecc_data_out,
  input  logic                               ecc_sbit_err,
  input  logic                               ecc_dbit_err,
  output logic [7:0]                         sbe_cnt,
  output logic [7:0]                         dbe_cnt,
  output logic [ADDR_WIDTH-1:0]              dbe_addr,
  output logic                               dbe_irq,
  output logic                               scrub_pass_done
);

  localparam int unsigned CW = DATA_WIDTH + PARITY_WIDTH;
  localparam int unsigned IW = $clog2(SCRUB_INTERVAL);
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = '1;
  localparam logic [IW-1:0]         IVL_LAST   = IW'(SCRUB_INTERVAL - 1);
  localparam logic [SW-1:0]         STARVE_MAX = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, RD_CHK, SCR_CHK, SCR_WB} state_e;

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  saddr_q, saddr_d;
  logic [ADDR_WIDTH-1:0]  rd_addr_q, rd_addr_d;
  logic [ADDR_WIDTH-1:0]  dbe_addr_q, dbe_addr_d;
  logic                   pend_q, pend_d;
  logic [IW-1:0]          ivl_q, ivl_d;
  logic [SW-1:0]          starve_q, starve_d;
  logic [7:0]             sbe_q, sbe_d, dbe_q, dbe_d;
  logic [DATA_WIDTH-1:0]  cap_q, cap_d;
  logic                   sbit_v, dbit_v, sbe_inc, dbe_inc, advance;

  // State and bookkeeping registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      saddr_q    <= '0;
      rd_addr_q  <= '0;
      dbe_addr_q <= '0;
      pend_q     <= 1'b0;
      ivl_q      <= '0;
      starve_q   <= '0;
      sbe_q      <= '0;
      dbe_q      <= '0;
      cap_q      <= '0;
    end else begin
      state_q    <= state_d;
      saddr_q    <= saddr_d;
      rd_addr_q  <= rd_addr_d;
      dbe_addr_q <= dbe_addr_d;
      pend_q     <= pend_d;
      ivl_q      <= ivl_d;
      starve_q   <= starve_d;
      sbe_q      <= sbe_d;
      dbe_q      <= dbe_d;
      cap_q      <= cap_d;
    end
  end

  // Arbitration, memory/codec steering and next-state logic
  always_comb begin
    state_d         = state_q;
    saddr_d         = saddr_q;
    rd_addr_d       = rd_addr_q;
    dbe_addr_d      = dbe_addr_q;
    pend_d          = pend_q;
    ivl_d           = ivl_q;
    starve_d        = starve_q;
    sbe_d           = sbe_q;
    dbe_d           = dbe_q;
    cap_d           = cap_q;
    host_gnt        = 1'b0;
    host_rvalid     = 1'b0;
    host_rdata      = ecc_data_out;
    host_sbit_err   = 1'b0;
    host_dbit_err   = 1'b0;
    mem_en          = 1'b0;
    mem_we          = 1'b0;
    mem_addr        = host_addr;
    ecc_data_in     = mem_rdata[DATA_WIDTH-1:0];
    ecc_parity_in   = mem_rdata[CW-1:DATA_WIDTH];
    dbe_irq         = 1'b0;
    scrub_pass_done = 1'b0;
    sbe_inc         = 1'b0;
    dbe_inc         = 1'b0;
    advance         = 1'b0;
    sbit_v          = ecc_sbit_err && !cfg_bypass;
    dbit_v          = ecc_dbit_err && !cfg_bypass;

    if (scrub_en && !pend_q) begin
      if (ivl_q == IVL_LAST) begin
        ivl_d  = '0;
        pend_d = 1'b1;
      end else begin
        ivl_d = ivl_q + IW'(1);
      end
    end

    case (state_q)
      IDLE: begin
        if (pend_q && (!host_req || starve_q == STARVE_MAX)) begin
          mem_en   = 1'b1;
          mem_addr = saddr_q;
          pend_d   = 1'b0;
          starve_d = '0;
          state_d  = SCR_CHK;
        end else if (host_req) begin
          host_gnt = 1'b1;
          mem_en   = 1'b1;
          if (pend_q && starve_q != STARVE_MAX) starve_d = starve_q + SW'(1);
          if (host_we) begin
            mem_we      = 1'b1;
            ecc_data_in = host_wdata;
          end else begin
            rd_addr_d = host_addr;
            state_d   = RD_CHK;
          end
        end
      end
      RD_CHK: begin
        host_rvalid   = 1'b1;
        host_sbit_err = sbit_v;
        host_dbit_err = dbit_v;
        sbe_inc       = sbit_v;
        dbe_inc       = dbit_v;
        if (dbit_v) begin
          dbe_irq    = 1'b1;
          dbe_addr_d = rd_addr_q;
        end
        state_d = IDLE;
      end
      SCR_CHK: begin
        sbe_inc = sbit_v;
        dbe_inc = dbit_v;
        if (dbit_v) begin
          dbe_irq    = 1'b1;
          dbe_addr_d = saddr_q;
        end
`ifdef ECC_SCRUB_WB_EN
        if (sbit_v && !dbit_v) begin
          cap_d   = ecc_data_out;
          state_d = SCR_WB;
        end else begin
          advance = 1'b1;
          state_d = IDLE;
        end
`else
        advance = 1'b1;
        state_d = IDLE;
`endif
      end
      SCR_WB: begin
        mem_en      = 1'b1;
        mem_we      = 1'b1;
        mem_addr    = saddr_q;
        ecc_data_in = cap_q;
        advance     = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (advance) begin
      saddr_d         = saddr_q + ADDR_WIDTH'(1);
      scrub_pass_done = (saddr_q == LAST_ADDR);
    end

    // Clear has priority over a same-cycle error increment
    if (cnt_clr) sbe_d = '0;
    else if (sbe_inc && sbe_q != 8'hFF) sbe_d = sbe_q + 8'd1;
    if (cnt_clr) dbe_d = '0;
    else if (dbe_inc && dbe_q != 8'hFF) dbe_d = dbe_q + 8'd1;

    mem_wdata = {ecc_parity_out, ecc_data_in};

    if (rst) begin
      host_gnt        = 1'b0;
      host_rvalid     = 1'b0;
      host_sbit_err   = 1'b0;
      host_dbit_err   = 1'b0;
      mem_en          = 1'b0;
      mem_we          = 1'b0;
      dbe_irq         = 1'b0;
      scrub_pass_done = 1'b0;
    end
  end

  assign ecc_bypass = cfg_bypass;
  assign sbe_cnt    = sbe_q;
  assign dbe_cnt    = dbe_q;
  assign dbe_addr   = dbe_addr_q;

endmodule

// File: tb/tb_ecc_scrub_ctrl.sv
// Scoreboard bench for ecc_scrub_ctrl with a behavioural SECDED codec and memory.
module tb_ecc_scrub_ctrl;
  localparam int unsigned DW = 23, PW = 6, AW = 5, CW = 29, SI = 64, SL = 8;
`ifdef ECC_SCRUB_WB_EN
  localparam bit WB = 1'b1;
`else
  localparam bit WB = 1'b0;
`endif

  logic clk, rst, scrub_en, cfg_bypass, cnt_clr, host_req, host_we;
  logic [AW-1:0] host_addr, mem_addr, dbe_addr;
  logic [DW-1:0] host_wdata, host_rdata, ecc_data_in, ecc_data_out;
  logic host_gnt, host_rvalid, host_sbit_err, host_dbit_err, mem_en, mem_we;
  logic [CW-1:0] mem_wdata, mem_rdata;
  logic [PW-1:0] ecc_parity_in, ecc_parity_out;
  logic ecc_bypass, ecc_sbit_err, ecc_dbit_err, dbe_irq, scrub_pass_done;
  logic [7:0] sbe_cnt, dbe_cnt;

  ecc_scrub_ctrl dut (
    .clk(clk), .rst(rst), .scrub_en(scrub_en), .cfg_bypass(cfg_bypass), .cnt_clr(cnt_clr),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .host_sbit_err(host_sbit_err), .host_dbit_err(host_dbit_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .ecc_data_in(ecc_data_in), .ecc_parity_in(ecc_parity_in),
    .ecc_bypass(ecc_bypass), .ecc_parity_out(ecc_parity_out), .ecc_data_out(ecc_data_out),
    .ecc_sbit_err(ecc_sbit_err), .ecc_dbit_err(ecc_dbit_err), .sbe_cnt(sbe_cnt),
    .dbe_cnt(dbe_cnt), .dbe_addr(dbe_addr), .dbe_irq(dbe_irq), .scrub_pass_done(scrub_pass_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hamming(28) + overall parity: check bits at positions 1,2,4,8,16
  function automatic logic [4:0] hsyn(input logic [22:0] d, input logic [4:0] p);
    logic [4:0] s; int k; int j;
    s = '0; k = 0; j = 0;
    for (int pos = 1; pos <= 28; pos++) begin
      if ((pos & (pos - 1)) == 0) begin
        if (p[j]) s ^= 5'(pos);
        j++;
      end else begin
        if (d[k]) s ^= 5'(pos);
        k++;
      end
    end
    return s;
  endfunction

  function automatic logic [5:0] enc(input logic [22:0] d);
    logic [4:0] h;
    h = hsyn(d, 5'd0);
    return {^{d, h}, h};
  endfunction

  function automatic logic [24:0] dec(input logic [22:0] d, input logic [5:0] p);
    logic [4:0] s; logic [22:0] o; logic sb, db; int k;
    s = hsyn(d, p[4:0]); o = d; sb = 1'b0; db = 1'b0; k = 0;
    if (^{d, p}) begin
      sb = 1'b1;
      for (int pos = 1; pos <= 28; pos++) begin
        if ((pos & (pos - 1)) != 0) begin
          if (5'(pos) == s) o[k] = ~o[k];
          k++;
        end
      end
    end else if (s != 5'd0) begin
      db = 1'b1;
    end
    return {sb, db, o};
  endfunction

  function automatic logic [28:0] word(input logic [22:0] d);
    return {enc(d), d};
  endfunction

  logic [24:0] dec_r;
  always_comb begin
    ecc_parity_out = enc(ecc_data_in);
    dec_r = dec(ecc_data_in, ecc_parity_in);
    if (ecc_bypass) begin
      ecc_data_out = ecc_data_in; ecc_sbit_err = 1'b0; ecc_dbit_err = 1'b0;
    end else begin
      ecc_data_out = dec_r[22:0]; ecc_sbit_err = dec_r[24]; ecc_dbit_err = dec_r[23];
    end
  end

  logic [CW-1:0] mem [32];
  logic tb_init, poke_req;
  logic [AW-1:0] poke_addr;
  logic [CW-1:0] poke_val;
  always @(posedge clk) begin
    if (tb_init) for (int i = 0; i < 32; i++) mem[i] <= '0;
    else if (poke_req) mem[poke_addr] <= poke_val;
    else if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
  end

  int n_cmp = 0, n_bad = 0;
  int scrub_wr = 0, irq_cnt = 0, pass_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct packed { logic [22:0] d; logic s; logic db; } rsp_t;
  rsp_t exp_q[$];

  wire [7:0] strobes = {host_gnt, host_rvalid, mem_en, mem_we, dbe_irq, scrub_pass_done,
                        host_sbit_err, host_dbit_err};

  // Response monitor and event counters
  always @(negedge clk) begin
    if (host_rvalid) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL rsp_unexpected: got rdata 0x%0h with no pending read", host_rdata);
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        check("rsp_data", 32'(host_rdata), 32'(e.d));
        check("rsp_sbit", 32'(host_sbit_err), 32'(e.s));
        check("rsp_dbit", 32'(host_dbit_err), 32'(e.db));
      end
    end
    if (mem_en && mem_we && !host_gnt) scrub_wr++;
    if (dbe_irq) irq_cnt++;
    if (scrub_pass_done) pass_cnt++;
  end

  task automatic host_op(input logic we, input logic [4:0] a, input logic [22:0] d,
                         input logic [22:0] ed, input logic es, input logic edb, input logic clr);
    logic ok;
    ok = 1'b0;
    @(posedge clk); #1;
    host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (host_gnt) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL grant_timeout: got no grant for addr %0d expected grant", a);
    end
    if (!we && ok) exp_q.push_back('{d: ed, s: es, db: edb});
    @(posedge clk); #1;
    host_req = 1'b0;
    if (!we && clr) cnt_clr = 1'b1;
    if (!we && ok) begin
      @(negedge clk);
      check("rd_latency", 32'(host_rvalid), 32'd1);
    end
    if (clr) begin @(posedge clk); #1; cnt_clr = 1'b0; end
  endtask

  task automatic wr(input logic [4:0] a, input logic [22:0] d);
    host_op(1'b1, a, d, 23'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic rd(input logic [4:0] a, input logic [22:0] ed, input logic es, input logic edb);
    host_op(1'b0, a, 23'd0, ed, es, edb, 1'b0);
  endtask

  task automatic wait_scrub(input logic [4:0] exp_a);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (mem_en && !mem_we && !host_gnt) begin
        check("scrub_addr", 32'(mem_addr), 32'(exp_a));
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL scrub_timeout: got no scrub read expected addr %0d", exp_a);
    end
  endtask

  task automatic poke(input logic [4:0] a, input logic [28:0] v);
    @(posedge clk); #1;
    poke_req = 1'b1; poke_addr = a; poke_val = v;
    @(posedge clk); #1;
    poke_req = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1; rst = 1'b1;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0; tb_init = 1'b0;
  endtask

  int n, wr0, irq0, pass0;
  logic [28:0] bad0;

  initial begin
    rst = 1'b1; tb_init = 1'b1; poke_req = 1'b0; poke_addr = '0; poke_val = '0;
    scrub_en = 1'b0; cfg_bypass = 1'b0; cnt_clr = 1'b0;
    host_req = 1'b1; host_we = 1'b1; host_addr = '0; host_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_strobes", 32'(strobes), 32'd0);
    host_req = 1'b0;
    do_reset();
    @(negedge clk);
    check("rst_sbe", 32'(sbe_cnt), 32'd0);
    check("rst_dbe", 32'(dbe_cnt), 32'd0);
    check("rst_dbe_addr", 32'(dbe_addr), 32'd0);

    // Starvation: continuous host writes; scrub must win after STARVE_LIMIT cycles
    do_reset();
    scrub_en = 1'b1; host_req = 1'b1; host_we = 1'b1; host_addr = 5'd20; host_wdata = 23'h55;
    n = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (!host_gnt) break;
      n++;
      @(posedge clk); #1;
    end
    check("starve_cycle", 32'(n), 32'(SI + SL));
    check("starve_scrub_rd", 32'({mem_en, mem_we, mem_addr}), 32'({1'b1, 1'b0, 5'd0}));
    @(posedge clk); #1; host_req = 1'b0; scrub_en = 1'b0;

    // Basic write/read patterns
    wr(5'd3, 23'h12345);  rd(5'd3, 23'h12345, 1'b0, 1'b0);
    wr(5'd0, 23'h7FFFFF); wr(5'd31, 23'h000001); wr(5'd10, 23'h2AAAAA);
    rd(5'd0, 23'h7FFFFF, 1'b0, 1'b0);
    rd(5'd31, 23'h000001, 1'b0, 1'b0);
    rd(5'd10, 23'h2AAAAA, 1'b0, 1'b0);
    wr(5'd5, 23'h0F0F0); wr(5'd7, 23'h13579); wr(5'd9, 23'h1BEEF);
    rd(5'd20, 23'h55, 1'b0, 1'b0);

    // Single-bit error at addr 5 found by the scrubber
    poke(5'd5, word(23'h0F0F0) ^ 29'h1);
    wr0 = scrub_wr;
    scrub_en = 1'b1;
    for (int a = 1; a <= 5; a++) wait_scrub(5'(a));
    @(posedge clk); #1; scrub_en = 1'b0;
    repeat (3) @(negedge clk);
    check("sbe_after_scrub", 32'(sbe_cnt), 32'd1);
    check("scrub_wb_count", 32'(scrub_wr - wr0), 32'(WB));
    check("mem5_after_scrub", 32'(mem[5]), WB ? 32'(word(23'h0F0F0)) : 32'(word(23'h0F0F0) ^ 29'h1));
    rd(5'd5, 23'h0F0F0, !WB, 1'b0);
    @(negedge clk);
    check("sbe_after_reread", 32'(sbe_cnt), WB ? 32'd1 : 32'd2);

    // Double-bit error at addr 7 found by the scrubber, then by a host read
    poke(5'd7, word(23'h13579) ^ 29'h3);
    wr0 = scrub_wr; irq0 = irq_cnt;
    scrub_en = 1'b1;
    wait_scrub(5'd6); wait_scrub(5'd7);
    @(posedge clk); #1; scrub_en = 1'b0;
    repeat (3) @(negedge clk);
    check("dbe_cnt", 32'(dbe_cnt), 32'd1);
    check("dbe_addr", 32'(dbe_addr), 32'd7);
    check("dbe_irq_pulses", 32'(irq_cnt - irq0), 32'd1);
    check("dbe_no_wb", 32'(scrub_wr - wr0), 32'd0);
    rd(5'd7, 23'h13579 ^ 23'h3, 1'b0, 1'b1);
    @(negedge clk);
    check("dbe_cnt_host", 32'(dbe_cnt), 32'd2);
    check("dbe_irq_host", 32'(irq_cnt - irq0), 32'd2);

    // Bypass: raw data, no flags, no counting
    cfg_bypass = 1'b1;
    rd(5'd7, 23'h13579 ^ 23'h3, 1'b0, 1'b0);
    @(negedge clk);
    check("bypass_pin", 32'(ecc_bypass), 32'd1);
    check("bypass_dbe_cnt", 32'(dbe_cnt), 32'd2);
    check("bypass_sbe_cnt", 32'(sbe_cnt), WB ? 32'd1 : 32'd2);
    cfg_bypass = 1'b0;

    // Full scrub pass over clean memory
    poke(5'd5, word(23'h0F0F0));
    poke(5'd7, word(23'h13579));
    do_reset();
    @(negedge clk);
    check("rst_dbe_addr2", 32'(dbe_addr), 32'd0);
    pass0 = pass_cnt;
    @(posedge clk); #1; scrub_en = 1'b1;
    for (int a = 0; a < 32; a++) wait_scrub(5'(a));
    wait_scrub(5'd0);
    @(posedge clk); #1; scrub_en = 1'b0;
    repeat (2) @(negedge clk);
    check("pass_done_pulses", 32'(pass_cnt - pass0), 32'd1);
    check("pass_sbe", 32'(sbe_cnt), 32'd0);

    // Saturation at 255, then clear beating a same-cycle error
    poke(5'd9, word(23'h1BEEF) ^ 29'h10);
    for (int i = 0; i < 300; i++) rd(5'd9, 23'h1BEEF, 1'b1, 1'b0);
    @(negedge clk);
    check("sbe_saturate", 32'(sbe_cnt), 32'd255);
    host_op(1'b0, 5'd9, 23'd0, 23'h1BEEF, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    check("sbe_clr_wins", 32'(sbe_cnt), 32'd0);

    // Reset during a host write grant
    @(posedge clk); #1;
    host_req = 1'b1; host_we = 1'b1; host_addr = 5'd12; host_wdata = 23'h1; rst = 1'b1;
    @(negedge clk);
    check("rst_in_hostwr", 32'(strobes), 32'd0);
    @(posedge clk); #1; rst = 1'b0; host_req = 1'b0;
    @(negedge clk);
    check("post_rst_strobes", 32'(strobes), 32'd0);

    // Reset in the cycle after the scrub check of a single-bit error
    bad0 = mem[0] ^ 29'h1;
    poke(5'd0, bad0);
    wr0 = scrub_wr;
    scrub_en = 1'b1;
    wait_scrub(5'd0);
    @(posedge clk); #1; scrub_en = 1'b0;
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    check("rst_in_wb_strobes", 32'(strobes), 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("rst_wb_sbe", 32'(sbe_cnt), 32'd0);
    check("rst_wb_no_write", 32'(scrub_wr - wr0), 32'd0);
    check("rst_wb_mem0", 32'(mem[0]), 32'(bad0));
    check("rst_wb_strobes2", 32'(strobes), 32'd0);

    repeat (5) @(negedge clk);
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ecc_scrub_ctrl.md
ECC_SCRUB_CTRL -- requirements
Module: ecc_scrub_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 23: protected data width.
REQ-002 SHALL have parameter PARITY_WIDTH, default 6: SECDED check-bit width.
REQ-003 SHALL have parameter ADDR_WIDTH, default 5: memory address width; depth = 2**ADDR_WIDTH.
REQ-004 SHALL have parameter SCRUB_INTERVAL, default 64: idle cycles between scrub steps (>=2).
REQ-005 SHALL have parameter STARVE_LIMIT, default 8: cycles a pending scrub may be blocked before it overrides the host.
REQ-006 Ports: clk in 1, the single clock; rst in 1, synchronous active-high reset.
REQ-007 Ports: scrub_en in 1; cfg_bypass in 1; cnt_clr in 1.
REQ-008 Ports: host_req in 1; host_we in 1; host_addr in ADDR_WIDTH; host_wdata in DATA_WIDTH; host_gnt out 1; host_rvalid out 1; host_rdata out DATA_WIDTH; host_sbit_err out 1; host_dbit_err out 1.
REQ-009 Ports: mem_en out 1; mem_we out 1; mem_addr out ADDR_WIDTH; mem_wdata out DATA_WIDTH+PARITY_WIDTH as {parity,data}; mem_rdata in DATA_WIDTH+PARITY_WIDTH, valid one cycle after mem_en with mem_we=0.
REQ-010 Ports to external combinational SECDED codec: ecc_data_in out DATA_WIDTH; ecc_parity_in out PARITY_WIDTH; ecc_bypass out 1; ecc_parity_out in PARITY_WIDTH; ecc_data_out in DATA_WIDTH; ecc_sbit_err in 1; ecc_dbit_err in 1.
REQ-011 Ports: sbe_cnt out 8; dbe_cnt out 8; dbe_addr out ADDR_WIDTH; dbe_irq out 1; scrub_pass_done out 1.

Function
REQ-012 FSM states SHALL be IDLE, RD_CHK, SCR_CHK, SCR_WB.
REQ-013 IDLE arbitration: scrub issue when scrub_pending and (!host_req or starve_cnt==STARVE_LIMIT); else host granted if host_req; host_gnt combinational in that cycle.
REQ-014 Host write grant: mem_en=mem_we=1, mem_addr=host_addr, ecc_data_in=host_wdata, mem_wdata={ecc_parity_out,host_wdata}; stay IDLE; back-to-back writes every cycle allowed.
REQ-015 Host read grant: mem_en=1, mem_we=0 -> RD_CHK; in RD_CHK ecc_data_in/ecc_parity_in=mem_rdata fields, host_rvalid=1, host_rdata=ecc_data_out, host_*_err=codec flags, host_gnt=0; -> IDLE. Read latency 1 cycle after grant.
REQ-016 Scrub issue: mem_en=1, mem_addr=scrub_addr -> SCR_CHK; scrub_pending cleared, starve_cnt cleared.
REQ-017 SCR_CHK: codec fed from mem_rdata; on ecc_sbit_err (macro enabled) capture ecc_data_out -> SCR_WB; otherwise advance scrub_addr -> IDLE.
REQ-018 SCR_WB: mem_en=mem_we=1, mem_addr=scrub_addr, ecc_data_in=captured data, mem_wdata={ecc_parity_out,captured}; advance scrub_addr -> IDLE.
REQ-019 host_gnt SHALL be 0 in RD_CHK, SCR_CHK, SCR_WB; no host write can intervene between scrub check and write-back.
REQ-020 scrub_addr wraps DEPTH-1 -> 0; scrub_pass_done pulses 1 cycle on that wrap.
REQ-021 Interval counter increments while scrub_en && !scrub_pending; at SCRUB_INTERVAL-1 sets scrub_pending, counter -> 0; scrub_en=0 holds counter, pending kept.
REQ-022 starve_cnt increments while scrub_pending and host wins IDLE, saturates at STARVE_LIMIT.
REQ-023 sbe_cnt/dbe_cnt increment on sbit/dbit flags in RD_CHK or SCR_CHK, saturate at 255; cnt_clr clears and wins over same-cycle increment.
REQ-024 Double-bit error in any check state: dbe_addr captures checked address, dbe_irq pulses 1 cycle; no write-back.
REQ-025 ecc_bypass=cfg_bypass; codec reports no errors in bypass, so no counting or write-back.

Reset
REQ-026 On rst: state IDLE, scrub_addr 0, pending 0, all counters 0, dbe_addr 0, captured data 0.
REQ-027 While rst=1 all strobes (host_gnt, host_rvalid, mem_en, mem_we, dbe_irq, scrub_pass_done, host_*_err) SHALL be 0; reset in SCR_WB aborts the write.

Configuration
REQ-028 Macro ECC_SCRUB_WB_EN defined: SCR_CHK single-bit error -> SCR_WB write-back of corrected data.
REQ-029 Macro ECC_SCRUB_WB_EN undefined: SCR_WB unreachable, single-bit errors only counted, scrub always SCR_CHK -> IDLE.

Verification
REQ-030 Write addr 3 data 0x12345, read addr 3 -> host_rvalid next cycle, host_rdata 0x12345, no error flags.
REQ-031 Flip stored data bit 0 at addr 5, run scrub -> sbe_cnt=1, SCR_WB writes corrected word (WB_EN), re-read shows no error; without WB_EN re-read flags sbit again.
REQ-032 Flip two bits at addr 7 -> dbe_cnt=1, dbe_addr=7, dbe_irq one-cycle pulse, no mem_we.
REQ-033 host_req held high continuously with scrub pending -> scrub issues exactly STARVE_LIMIT cycles after pending, host_gnt=0 that cycle.
REQ-034 Run 32 scrub steps (ADDR_WIDTH=5) -> scrub_pass_done pulses once, scrub_addr back to 0; 300 forced sbit errors -> sbe_cnt=255; cnt_clr with error same cycle -> 0.
REQ-035 Assert rst during SCR_WB -> mem_we=0 that cycle, all outputs at reset values next cycle.
